// File: rtl/alu_share_arb.sv
// Two-requester round-robin front end sharing one registered ALU.
// add/sub/max finish in one EXEC cycle; multiply is a WIDTH-cycle shift-add.
module alu_share_arb #(
  parameter int WIDTH = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req0,
  input  logic [1:0]         op0,
  input  logic [WIDTH-1:0]   a0,
  input  logic [WIDTH-1:0]   b0,
  output logic               gnt0,
  input  logic               req1,
  input  logic [1:0]         op1,
  input  logic [WIDTH-1:0]   a1,
  input  logic [WIDTH-1:0]   b1,
  output logic               gnt1,
  output logic [2*WIDTH-1:0] res,
  output logic               res_valid,
  output logic               res_id,
  output logic               busy
);

  localparam int RW = 2 * WIDTH;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MAX = 2'b10;
  localparam logic [1:0] OP_MUL = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t          state_reg;
  state_t          state_next;

  logic [1:0]      op_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic            id_reg;
  logic            rr_ptr_reg;     // requester that wins the next tie
  logic [CW-1:0]   cnt_reg;
  logic [RW-1:0]   acc_reg;
  logic [RW-1:0]   res_reg;
  logic            res_id_reg;
  logic            gnt0_reg;
  logic            gnt1_reg;

  logic            any_req;
  logic            win;
  logic [RW-1:0]   a_ext;
  logic [RW-1:0]   b_ext;
  logic [RW-1:0]   partial;
  logic [RW-1:0]   acc_sum;
  logic [RW-1:0]   alu_res;
  logic            last_step;

  // Arbitration: a lone requester wins outright; a tie goes to the pointer.
  assign any_req = req0 | req1;
  assign win     = (req0 && req1) ? rr_ptr_reg : req1;

  assign a_ext   = {{WIDTH{1'b0}}, a_reg};
  assign b_ext   = {{WIDTH{1'b0}}, b_reg};
  assign partial = b_reg[cnt_reg] ? (a_ext << cnt_reg) : '0;
  assign acc_sum = acc_reg + partial;

  always_comb begin
    alu_res = '0;
    case (op_reg)
      OP_ADD:  alu_res = a_ext + b_ext;
      OP_SUB:  alu_res = a_ext - b_ext;
      OP_MAX:  alu_res = (a_reg > b_reg) ? a_ext : b_ext;
      OP_MUL:  alu_res = acc_sum;
      default: alu_res = '0;
    endcase
  end

  assign last_step = (op_reg != OP_MUL) || (cnt_reg == CNT_LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (any_req) state_next = S_EXEC;
      S_EXEC:  if (last_step) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Operand capture, multiply iteration and result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_reg     <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      id_reg     <= 1'b0;
      rr_ptr_reg <= 1'b0;
      cnt_reg    <= '0;
      acc_reg    <= '0;
      res_reg    <= '0;
      res_id_reg <= 1'b0;
      gnt0_reg   <= 1'b0;
      gnt1_reg   <= 1'b0;
    end else begin
      gnt0_reg <= 1'b0;
      gnt1_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (any_req) begin
            op_reg     <= win ? op1 : op0;
            a_reg      <= win ? a1 : a0;
            b_reg      <= win ? b1 : b0;
            id_reg     <= win;
            rr_ptr_reg <= ~win;
            gnt0_reg   <= ~win;
            gnt1_reg   <= win;
            cnt_reg    <= '0;
            acc_reg    <= '0;
          end
        end
        S_EXEC: begin
          if (last_step) begin
            res_reg    <= alu_res;
            res_id_reg <= id_reg;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
            acc_reg <= acc_sum;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Outputs
  always_comb begin
    gnt0      = gnt0_reg;
    gnt1      = gnt1_reg;
    res       = res_reg;
    res_id    = res_id_reg;
    res_valid = (state_reg == S_DONE);
    busy      = (state_reg != S_IDLE);
  end

endmodule

// File: tb/tb_alu_share_arb.sv
// Randomised and directed bench for alu_share_arb; expectations come from an
// arithmetic/arbitration model and cycle offsets derived from the latency rules.
module tb_alu_share_arb;

  localparam int W  = 5;
  localparam int RW = 2 * W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0 = 1'b0, req1 = 1'b0;
  logic [1:0]    op0 = '0, op1 = '0;
  logic [W-1:0]  a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic          gnt0, gnt1, res_valid, res_id, busy;
  logic [RW-1:0] res;

  int n_checks = 0;
  int n_fail   = 0;

  // Observations from the last run_reqs call
  int            ng, nv, viol;
  bit            timeout;
  bit            g_id[4];
  int            g_off[4];
  int            v_off[4];
  logic [RW-1:0] v_res[4];
  logic          v_id[4];

  // Model state: which requester wins the next tie
  bit next_tie = 1'b0;

  alu_share_arb #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .op0(op0), .a0(a0), .b0(b0), .gnt0(gnt0),
    .req1(req1), .op1(op1), .a1(a1), .b1(b1), .gnt1(gnt1),
    .res(res), .res_valid(res_valid), .res_id(res_id), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [RW-1:0] model_res(input logic [1:0] op, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
    int ai, bi, r;
    ai = int'(a);
    bi = int'(b);
    case (op)
      2'd0:    r = ai + bi;
      2'd1:    r = ai - bi;
      2'd2:    r = (ai > bi) ? ai : bi;
      default: r = ai * bi;
    endcase
    return r[RW-1:0];
  endfunction

  function automatic int model_lat(input logic [1:0] op);
    return (op == 2'd3) ? W : 1;
  endfunction

  // Returns the first winner and advances the tie pointer past every grant.
  task automatic model_pick(input bit r0, input bit r1, output bit first);
    first = (r0 && r1) ? next_tie : r1;
    next_tie = ~first;
    if (r0 && r1) next_tie = first;
  endtask

  // Requester behaviour: raise req, drop it in the gnt cycle, record events.
  task automatic run_reqs(input bit r0, input bit r1,
                          input logic [1:0] o0, input logic [W-1:0] x0, input logic [W-1:0] y0,
                          input logic [1:0] o1, input logic [W-1:0] x1, input logic [W-1:0] y1);
    int t;
    int need;
    logic [RW-1:0] last_res;
    ng = 0; nv = 0; viol = 0; timeout = 1'b0; t = 0;
    need = int'(r0) + int'(r1);
    @(negedge clk);
    last_res = res;
    op0 = o0; a0 = x0; b0 = y0; req0 = r0;
    op1 = o1; a1 = x1; b1 = y1; req1 = r1;
    while (nv < need && t < 60) begin
      @(negedge clk);
      t++;
      if (gnt0 && gnt1) viol++;
      if ((gnt0 || gnt1 || res_valid) && !busy) viol++;
      if (gnt0 || gnt1) begin
        if (ng < 4) begin
          g_id[ng]  = gnt1;
          g_off[ng] = t;
        end
        ng++;
        if (gnt0) req0 = 1'b0;
        if (gnt1) req1 = 1'b0;
      end
      if (res_valid) begin
        if (nv < 4) begin
          v_off[nv] = t;
          v_res[nv] = res;
          v_id[nv]  = res_id;
        end
        nv++;
        $display("txn id=%0d res=0x%0h cycle_offset=%0d", res_id, res, t);
      end else if (res !== last_res) begin
        viol++;
      end
      last_res = res;
    end
    if (nv < need) timeout = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_checks++;
    if ({gnt0, gnt1, res_valid, busy, res_id, res} !== '0) begin
      n_fail++;
      $display("FAIL reset_held outputs=0x%0h required=0", {gnt0, gnt1, res_valid, busy, res_id, res});
    end
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++;
      if ({gnt0, gnt1, res_valid, busy, res_id, res} !== '0) begin
        n_fail++;
        $display("FAIL reset_idle cycle=%0d outputs=0x%0h required=0", i,
                 {gnt0, gnt1, res_valid, busy, res_id, res});
      end
    end
  endtask

  task automatic test_add;
    bit f;
    model_pick(1'b1, 1'b0, f);
    run_reqs(1'b1, 1'b0, 2'd0, 5'd9, 5'd17, 2'd0, 5'd0, 5'd0);
    n_checks++;
    if ({g_id[0], g_off[0], v_off[0], v_res[0], v_id[0]} !== {1'b0, 32'd1, 32'd2, 10'd26, 1'b0}) begin
      n_fail++;
      $display("FAIL add gid=%0d goff=%0d voff=%0d res=%0d id=%0d required 0/1/2/26/0",
               g_id[0], g_off[0], v_off[0], v_res[0], v_id[0]);
    end
    n_checks++;
    if ({ng, viol, 31'd0, timeout} !== {32'd1, 32'd0, 32'd0}) begin
      n_fail++;
      $display("FAIL add_health grants=%0d viol=%0d timeout=%0d required 1/0/0", ng, viol, timeout);
    end
  endtask

  task automatic test_sub;
    bit f;
    model_pick(1'b0, 1'b1, f);
    run_reqs(1'b0, 1'b1, 2'd0, 5'd0, 5'd0, 2'd1, 5'd3, 5'd5);
    n_checks++;
    if ({g_id[0], g_off[0], v_off[0], v_res[0], v_id[0]} !== {1'b1, 32'd1, 32'd2, 10'h3FE, 1'b1}) begin
      n_fail++;
      $display("FAIL sub gid=%0d goff=%0d voff=%0d res=0x%0h id=%0d required 1/1/2/0x3fe/1",
               g_id[0], g_off[0], v_off[0], v_res[0], v_id[0]);
    end
    n_checks++;
    if ({ng, viol, 31'd0, timeout} !== {32'd1, 32'd0, 32'd0}) begin
      n_fail++;
      $display("FAIL sub_health grants=%0d viol=%0d timeout=%0d required 1/0/0", ng, viol, timeout);
    end
  endtask

  task automatic test_max;
    bit f;
    model_pick(1'b0, 1'b1, f);
    run_reqs(1'b0, 1'b1, 2'd0, 5'd0, 5'd0, 2'd2, 5'd7, 5'd7);
    n_checks++;
    if ({v_res[0], v_id[0], v_off[0]} !== {10'd7, 1'b1, 32'd2} || ng != 1 || timeout) begin
      n_fail++;
      $display("FAIL max_equal res=%0d id=%0d voff=%0d required 7/1/2", v_res[0], v_id[0], v_off[0]);
    end
    model_pick(1'b0, 1'b1, f);
    run_reqs(1'b0, 1'b1, 2'd0, 5'd0, 5'd0, 2'd2, 5'd31, 5'd2);
    n_checks++;
    if ({v_res[0], v_id[0], v_off[0]} !== {10'd31, 1'b1, 32'd2} || ng != 1 || timeout) begin
      n_fail++;
      $display("FAIL max_gt res=%0d id=%0d voff=%0d required 31/1/2", v_res[0], v_id[0], v_off[0]);
    end
  endtask

  task automatic test_mul_tie;
    bit f;
    model_pick(1'b1, 1'b1, f);
    run_reqs(1'b1, 1'b1, 2'd3, 5'd31, 5'd31, 2'd0, 5'd1, 5'd1);
    n_checks++;
    if ({g_id[0], g_off[0], v_off[0], v_res[0], v_id[0]} !== {1'b0, 32'd1, 32'd6, 10'd961, 1'b0}) begin
      n_fail++;
      $display("FAIL mul_first gid=%0d goff=%0d voff=%0d res=%0d id=%0d required 0/1/6/961/0",
               g_id[0], g_off[0], v_off[0], v_res[0], v_id[0]);
    end
    n_checks++;
    if ({g_id[1], g_off[1], v_off[1], v_res[1], v_id[1]} !== {1'b1, 32'd8, 32'd9, 10'd2, 1'b1}) begin
      n_fail++;
      $display("FAIL mul_loser gid=%0d goff=%0d voff=%0d res=%0d id=%0d required 1/8/9/2/1",
               g_id[1], g_off[1], v_off[1], v_res[1], v_id[1]);
    end
    n_checks++;
    if ({ng, viol, 31'd0, timeout} !== {32'd2, 32'd0, 32'd0}) begin
      n_fail++;
      $display("FAIL mul_health grants=%0d viol=%0d timeout=%0d required 2/0/0", ng, viol, timeout);
    end
  endtask

  task automatic test_back_to_back;
    bit f;
    model_pick(1'b1, 1'b1, f);
    run_reqs(1'b1, 1'b1, 2'd0, 5'd4, 5'd5, 2'd1, 5'd10, 5'd3);
    n_checks++;
    if ({g_id[0], g_off[0], v_off[0], v_res[0], v_id[0]} !== {1'b0, 32'd1, 32'd2, 10'd9, 1'b0}) begin
      n_fail++;
      $display("FAIL b2b_first gid=%0d goff=%0d voff=%0d res=%0d id=%0d required 0/1/2/9/0",
               g_id[0], g_off[0], v_off[0], v_res[0], v_id[0]);
    end
    n_checks++;
    if ({g_id[1], g_off[1], v_off[1], v_res[1], v_id[1]} !== {1'b1, 32'd4, 32'd5, 10'd7, 1'b1}) begin
      n_fail++;
      $display("FAIL b2b_second gid=%0d goff=%0d voff=%0d res=%0d id=%0d required 1/4/5/7/1",
               g_id[1], g_off[1], v_off[1], v_res[1], v_id[1]);
    end
  endtask

  task automatic test_reset_abort;
    int seen;
    bit f;
    seen = 0;
    @(negedge clk);
    op0 = 2'd3; a0 = 5'd31; b0 = 5'd31; req0 = 1'b1; req1 = 1'b0;
    @(negedge clk);
    req0 = 1'b0;
    n_checks++;
    if ({gnt0, busy} !== 2'b11) begin
      n_fail++;
      $display("FAIL abort_grant gnt0=%0d busy=%0d required 1/1", gnt0, busy);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({gnt0, gnt1, res_valid, busy, res_id, res} !== '0) begin
      n_fail++;
      $display("FAIL abort_async outputs=0x%0h required=0", {gnt0, gnt1, res_valid, busy, res_id, res});
    end
    next_tie = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (res_valid || busy || gnt0 || gnt1) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL abort_quiet active_cycles=%0d required 0", seen);
    end
    model_pick(1'b1, 1'b1, f);
    run_reqs(1'b1, 1'b1, 2'd1, 5'd20, 5'd6, 2'd2, 5'd3, 5'd9);
    n_checks++;
    if ({g_id[0], v_res[0], v_id[0], g_id[1], v_res[1], v_id[1]} !==
        {1'b0, 10'd14, 1'b0, 1'b1, 10'd9, 1'b1} || timeout) begin
      n_fail++;
      $display("FAIL abort_recover gid0=%0d res0=%0d gid1=%0d res1=%0d timeout=%0d required 0/14/1/9/0",
               g_id[0], v_res[0], g_id[1], v_res[1], timeout);
    end
  endtask

  task automatic test_random;
    int sel, l0, l1;
    bit r0, r1, first;
    logic [1:0] o0, o1, fo, so;
    logic [W-1:0] x0, y0, x1, y1, fa, fb, sa, sb;
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(1, 3);
      r0 = sel[0];
      r1 = sel[1];
      o0 = 2'($urandom_range(0, 3));
      o1 = 2'($urandom_range(0, 3));
      x0 = W'($urandom_range(0, 31));
      y0 = W'($urandom_range(0, 31));
      x1 = W'($urandom_range(0, 31));
      y1 = W'($urandom_range(0, 31));
      model_pick(r0, r1, first);
      fo = first ? o1 : o0; fa = first ? x1 : x0; fb = first ? y1 : y0;
      so = first ? o0 : o1; sa = first ? x0 : x1; sb = first ? y0 : y1;
      l0 = 1 + model_lat(fo);
      l1 = l0 + 2 + model_lat(so);
      run_reqs(r0, r1, o0, x0, y0, o1, x1, y1);
      n_checks++;
      if ({g_id[0], g_off[0], v_off[0], v_res[0], v_id[0]} !==
          {first, 32'd1, l0, model_res(fo, fa, fb), first}) begin
        n_fail++;
        $display("FAIL rand_first it=%0d gid=%0d goff=%0d voff=%0d res=0x%0h id=%0d required %0d/1/%0d/0x%0h/%0d",
                 i, g_id[0], g_off[0], v_off[0], v_res[0], v_id[0], first, l0, model_res(fo, fa, fb), first);
      end
      if (r0 && r1) begin
        n_checks++;
        if ({g_id[1], g_off[1], v_off[1], v_res[1], v_id[1]} !==
            {~first, l0 + 2, l1, model_res(so, sa, sb), ~first}) begin
          n_fail++;
          $display("FAIL rand_second it=%0d gid=%0d goff=%0d voff=%0d res=0x%0h id=%0d required %0d/%0d/%0d/0x%0h/%0d",
                   i, g_id[1], g_off[1], v_off[1], v_res[1], v_id[1], ~first, l0 + 2, l1,
                   model_res(so, sa, sb), ~first);
        end
      end
      n_checks++;
      if ({ng, viol, 31'd0, timeout} !== {int'(r0) + int'(r1), 32'd0, 32'd0}) begin
        n_fail++;
        $display("FAIL rand_health it=%0d grants=%0d viol=%0d timeout=%0d required %0d/0/0",
                 i, ng, viol, timeout, int'(r0) + int'(r1));
      end
    end
  endtask

  initial begin
    test_reset;
    test_add;
    test_sub;
    test_max;
    test_mul_tie;
    test_back_to_back;
    test_reset_abort;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
